rv_regfile_mp: RTL and testbench
================================

Name: rv_regfile_mp

Overview:
Parametrised multi-port integer register file for the RISC-V core.
- Successor to the single-write, two-read regfile.
- Adds configurable XLEN, register count, read-port count and write-port count.
- Adds deterministic write-port priority, per-port write-to-read bypass, and an integrated scoreboard (pending bits) that tells decode whether each operand is valid.
- Sits between decode/issue (read and issue ports) and writeback (write ports).

Parameters:
XLEN, 64, data width of each register
NREG, 32, number of architectural registers; power of two, at least 2
NRD, 2, number of read ports
NWR, 1, number of write ports
BYPASS, 1, 1 = same-cycle write data is forwarded to reads; 0 = reads return array contents only
AW (localparam), $clog2(NREG), register address width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
rd_en  in  NRD  per-port read enable
rd_addr  in  NRD*AW  packed read addresses; port i uses bits [i*AW +: AW]
rd_data  out  NRD*XLEN  packed read data, combinational
rd_valid  out  NRD  operand usable this cycle (not pending, or being bypassed)
wr_en  in  NWR  per-port write enable
wr_addr  in  NWR*AW  packed write addresses
wr_data  in  NWR*XLEN  packed write data
iss_en  in  1  issue of an instruction with a destination register
iss_addr  in  AW  destination of the issuing instruction; marks it pending
pending  out  NREG  scoreboard bit per register, registered

Behaviour:
- Reset: rst=1 at a clock edge sets all registers to 0 and all pending bits to 0.
- While rst=1: rd_data=0 and rd_valid=0 on all ports (combinational override).
- x0: writes to address 0 are dropped; reads of x0 return 0 with rd_valid=1; iss_addr=0 never sets pending[0].
- Write: at the edge with wr_en[j]=1 and wr_addr[j]!=0, reg[wr_addr[j]] <= wr_data[j].
- Write conflict: several enabled ports with the same address → highest port index wins, at the array and in the bypass.
- Read, rd_en[i]=0: rd_data port i = 0, rd_valid[i]=0.
- Read, rd_en[i]=1: rd_data = bypass value if BYPASS=1 and some enabled write port targets rd_addr[i] (nonzero) this cycle; otherwise reg[rd_addr[i]].
- Read latency: 0 cycles (combinational).
- Read-after-write: with BYPASS=0, written data is visible the cycle after the write edge.
- rd_valid[i] = rd_en[i] & (addr==0 | !pending[addr] | bypass hit).
  - With BYPASS=0, a pending register reads valid=0 until the cycle after its writeback.
- Scoreboard update, per register r != 0, at the edge:
  - set if iss_en & iss_addr==r;
  - else clear if any wr_en[j] & wr_addr[j]==r;
  - else hold.
- Issue and writeback to the same register in one cycle: set wins (new producer supersedes). The array is still updated with the write data.
- Write to a non-pending register is legal: data is written, the pending bit stays 0.
- pending output reflects registered state only; it does not include the current cycle's iss_en.
- No internal stall; the issue stage must not issue a second producer to a pending register unless it accepts WAW ordering by the last writeback.

Decomposition:
- Shared package rv_pkg holds XLEN default, NREG default, and the ZERO/ENABLE constants already used by the core.
- One sub-module, rv_rf_bypass: for a single read port, it takes the NWR write ports and returns a hit flag plus the highest-index matching data.
  - Instantiated NRD times.
- The array and scoreboard stay in the top.

Test Plan:
1. Reset → read x0..x31 on both ports: rd_data=0, pending=0; hold rst=1 and write x5=0xDEAD → x5 still 0 after rst falls.
2. Write x3=0x1234 (cycle n); read x3 at cycle n with BYPASS=1 → 0x1234, rd_valid=1. With BYPASS=0 → old value at n, 0x1234 at n+1.
3. Write x0=0xFFFF_FFFF → read x0 gives 0, rd_valid=1. iss_addr=0 → pending[0] stays 0.
4. NWR=2, both ports write x7 (0xAAAA on port 0, 0xBBBB on port 1) → bypass and array both give 0xBBBB.
5. Issue x9 → pending[9]=1 next cycle and read x9 rd_valid=0. Writeback x9=0x55 → same cycle rd_valid=1, data 0x55 (BYPASS=1); pending[9]=0 next cycle.
6. Same cycle iss_addr=x4 and writeback x4=0x77 → pending[4]=1 next cycle and reg x4=0x77. Then rst mid-sequence → all pending bits cleared, x4=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Constants shared across the integer pipeline: default machine widths
// and the one-bit enable/zero values used throughout the core.
package rv_pkg;
   localparam int   RV_XLEN = 64;
   localparam int   RV_NREG = 32;
   localparam logic ZERO    = 1'b0;
   localparam logic ENABLE  = 1'b1;
endpackage

// File: rtl/rv_regfile_mp_if.sv
// Read, write and issue bundle between decode/writeback (master) and the
// multi-port register file (slave). All multi-port fields are packed, port i at [i*W +: W].
interface rv_regfile_mp_if #(
   parameter int XLEN = rv_pkg::RV_XLEN,
   parameter int NREG = rv_pkg::RV_NREG,
   parameter int NRD  = 2,
   parameter int NWR  = 1
);
   localparam int AW = $clog2(NREG);

   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_valid;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic [NREG-1:0]     pending;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      input  rd_data, rd_valid, pending
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
      output rd_data, rd_valid, pending
   );
endinterface

// File: rtl/rv_rf_bypass.sv
// Write-to-read forwarding for one read port: reports whether any enabled
// write port targets the (nonzero) read address, and the highest-index match's data.
module rv_rf_bypass
   import rv_pkg::*;
#(
   parameter int XLEN = RV_XLEN,
   parameter int AW   = 5,
   parameter int NWR  = 1
) (
   input  logic [AW-1:0]       rd_addr,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   output logic                hit,
   output logic [XLEN-1:0]     data
);
   // NOTE: every output gets a default before the loop so no path leaves it
   // unassigned; otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      hit  = ZERO;
      data = '0;
      // Ascending scan: a later (higher-index) match overwrites an earlier one.
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && rd_addr != '0 && wr_addr[j*AW +: AW] == rd_addr) begin
            hit  = ENABLE;
            data = wr_data[j*XLEN +: XLEN];
         end
      end
   end
endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port integer register file with hardwired x0, optional same-cycle
// write bypass and a pending-bit scoreboard telling decode which operands are ready.
module rv_regfile_mp
   import rv_pkg::*;
#(
   parameter int XLEN   = RV_XLEN,
   parameter int NREG   = RV_NREG,
   parameter int NRD    = 2,
   parameter int NWR    = 1,
   parameter int BYPASS = 1
) (
   input logic            clk,
   input logic            rst,
   rv_regfile_mp_if.slave bus
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] wr_hit;
   logic [NREG-1:0] iss_hit;
   logic [NRD-1:0]  byp_hit;
   logic [XLEN-1:0] byp_data [NRD];

   // Per-register decode of this cycle's writebacks and issue; x0 never marked.
   always_comb begin
      wr_hit  = '0;
      iss_hit = '0;
      for (int j = 0; j < NWR; j++) begin
         if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
            wr_hit[bus.wr_addr[j*AW +: AW]] = ENABLE;
      end
      if (bus.iss_en && bus.iss_addr != '0)
         iss_hit[bus.iss_addr] = ENABLE;
   end

   // NOTE: state uses non-blocking assignments so every reader in this edge
   // sees the pre-edge value; repeated writes to one entry keep the last,
   // which gives the highest-index write port priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the array is reset because software relies on zeroed
         // registers; this rules out mapping it onto a reset-less RAM macro.
         for (int r = 0; r < NREG; r++)
            regs[r] <= '0;
         pend_q <= '0;
      end else begin
         for (int j = 0; j < NWR; j++) begin
            if (bus.wr_en[j] && bus.wr_addr[j*AW +: AW] != '0)
               regs[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*XLEN +: XLEN];
         end
         // A new producer supersedes a writeback landing in the same cycle.
         pend_q <= iss_hit | (pend_q & ~wr_hit);
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      rv_rf_bypass #(
         .XLEN (XLEN),
         .AW   (AW),
         .NWR  (NWR)
      ) u_bypass (
         .rd_addr (bus.rd_addr[i*AW +: AW]),
         .wr_en   (bus.wr_en),
         .wr_addr (bus.wr_addr),
         .wr_data (bus.wr_data),
         .hit     (byp_hit[i]),
         .data    (byp_data[i])
      );
   end

   always_comb begin
      bus.rd_data  = '0;
      bus.rd_valid = '0;
      for (int i = 0; i < NRD; i++) begin
         if (!rst && bus.rd_en[i]) begin
            if (BYPASS != 0 && byp_hit[i])
               bus.rd_data[i*XLEN +: XLEN] = byp_data[i];
            else if (bus.rd_addr[i*AW +: AW] != '0)
               bus.rd_data[i*XLEN +: XLEN] = regs[bus.rd_addr[i*AW +: AW]];
            bus.rd_valid[i] = (bus.rd_addr[i*AW +: AW] == '0)
                              || !pend_q[bus.rd_addr[i*AW +: AW]]
                              || (BYPASS != 0 && byp_hit[i]);
         end
      end
   end

   assign bus.pending = pend_q;
endmodule

// File: tb/tb_rv_regfile_mp.sv
// Drives a bypassing and a non-bypassing two-write-port register file with
// identical stimulus and compares both against a behavioural model every cycle.
module tb_rv_regfile_mp;
   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int NRD  = 2;
   localparam int NWR  = 2;
   localparam int AW   = 5;

   logic clk;
   logic rst;
   logic [NRD-1:0]      rd_en;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;

   int n_checks = 0;
   int n_errors = 0;

   rv_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_a ();
   rv_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus_b ();

   assign bus_a.rd_en    = rd_en;
   assign bus_a.rd_addr  = rd_addr;
   assign bus_a.wr_en    = wr_en;
   assign bus_a.wr_addr  = wr_addr;
   assign bus_a.wr_data  = wr_data;
   assign bus_a.iss_en   = iss_en;
   assign bus_a.iss_addr = iss_addr;
   assign bus_b.rd_en    = rd_en;
   assign bus_b.rd_addr  = rd_addr;
   assign bus_b.wr_en    = wr_en;
   assign bus_b.wr_addr  = wr_addr;
   assign bus_b.wr_data  = wr_data;
   assign bus_b.iss_en   = iss_en;
   assign bus_b.iss_addr = iss_addr;

   rv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (bus_a.slave)
   );

   rv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [XLEN-1:0] m_regs [NREG];
   logic [NREG-1:0] m_pend;
   bit              model_ok = 1'b0;

   function automatic bit written(input int r);
      for (int j = 0; j < NWR; j++)
         if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == r) return 1'b1;
      return 1'b0;
   endfunction

   // What read port i must show this cycle, for a file with or without bypass.
   function automatic void exp_read(input bit byp, input int i,
                                    output logic [63:0] d, output logic v);
      int a;
      a = int'(rd_addr[i*AW +: AW]);
      d = '0;
      v = 1'b0;
      if (rst || !rd_en[i]) return;
      if (a == 0) begin
         v = 1'b1;
         return;
      end
      if (byp) begin
         for (int j = NWR - 1; j >= 0; j--) begin
            if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) begin
               d = wr_data[j*XLEN +: XLEN];
               v = 1'b1;
               return;
            end
         end
      end
      d = m_regs[a];
      v = !m_pend[a];
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) m_regs[r] <= '0;
         m_pend   <= '0;
         model_ok <= 1'b1;
      end else begin
         for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wr_addr[j*AW +: AW] != '0)
               m_regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
         for (int r = 1; r < NREG; r++) begin
            if (iss_en && int'(iss_addr) == r) m_pend[r] <= 1'b1;
            else if (written(r))               m_pend[r] <= 1'b0;
         end
      end
   end

   // Compare process: both DUTs against the model, mid-cycle.
   always @(negedge clk) begin
      logic [63:0] ed;
      logic        ev;
      if (model_ok) begin
         for (int i = 0; i < NRD; i++) begin
            exp_read(1'b1, i, ed, ev);
            check($sformatf("byp rd_data[%0d]", i), bus_a.rd_data[i*XLEN +: XLEN], ed);
            check($sformatf("byp rd_valid[%0d]", i), 64'(bus_a.rd_valid[i]), 64'(ev));
            exp_read(1'b0, i, ed, ev);
            check($sformatf("nobyp rd_data[%0d]", i), bus_b.rd_data[i*XLEN +: XLEN], ed);
            check($sformatf("nobyp rd_valid[%0d]", i), 64'(bus_b.rd_valid[i]), 64'(ev));
         end
         check("byp pending", 64'(bus_a.pending), 64'(m_pend));
         check("nobyp pending", 64'(bus_b.pending), 64'(m_pend));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      rd_en    = '0;
      rd_addr  = '0;
      wr_en    = '0;
      wr_addr  = '0;
      wr_data  = '0;
      iss_en   = 1'b0;
      iss_addr = '0;
   endtask

   task automatic set_rd(input int p, input int a);
      rd_en[p]            = 1'b1;
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic set_wr(input int p, input int a, input logic [63:0] d);
      wr_en[p]                = 1'b1;
      wr_addr[p*AW +: AW]     = AW'(a);
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      step();
      step();

      // Writes during reset are dropped; outputs forced to zero.
      set_wr(0, 5, 64'hDEAD);
      set_rd(0, 5);
      set_rd(1, 5);
      @(negedge clk);
      check("rst rd_data", bus_a.rd_data[63:0], 64'h0);
      check("rst rd_valid", 64'(bus_a.rd_valid), 64'h0);
      step();
      rst = 1'b0;
      idle();
      set_rd(0, 5);
      @(negedge clk);
      check("x5 after rst", bus_a.rd_data[63:0], 64'h0);
      check("x5 valid after rst", 64'(bus_a.rd_valid[0]), 64'h1);
      check("pending after rst", 64'(bus_a.pending), 64'h0);
      step();
      for (int k = 0; k < NREG; k++) begin
         idle();
         set_rd(0, k);
         set_rd(1, NREG - 1 - k);
         @(negedge clk);
         check("reset reg p0", bus_a.rd_data[63:0], 64'h0);
         check("reset reg p1", bus_a.rd_data[127:64], 64'h0);
         step();
      end

      // Write x3: bypass sees it now, plain array next cycle.
      idle();
      set_wr(0, 3, 64'h1234);
      set_rd(0, 3);
      @(negedge clk);
      check("x3 bypass", bus_a.rd_data[63:0], 64'h1234);
      check("x3 bypass valid", 64'(bus_a.rd_valid[0]), 64'h1);
      check("x3 nobyp old", bus_b.rd_data[63:0], 64'h0);
      step();
      idle();
      set_rd(0, 3);
      @(negedge clk);
      check("x3 nobyp next", bus_b.rd_data[63:0], 64'h1234);
      step();

      // x0 is hardwired and never pending.
      idle();
      set_wr(0, 0, 64'hFFFF_FFFF);
      iss_en = 1'b1;
      set_rd(0, 0);
      @(negedge clk);
      check("x0 bypass", bus_a.rd_data[63:0], 64'h0);
      check("x0 valid", 64'(bus_a.rd_valid[0]), 64'h1);
      step();
      idle();
      set_rd(0, 0);
      @(negedge clk);
      check("x0 array", bus_a.rd_data[63:0], 64'h0);
      check("x0 pending", 64'(bus_a.pending[0]), 64'h0);
      step();

      // Two ports write x7: higher index wins.
      idle();
      set_wr(0, 7, 64'hAAAA);
      set_wr(1, 7, 64'hBBBB);
      set_rd(0, 7);
      @(negedge clk);
      check("x7 bypass prio", bus_a.rd_data[63:0], 64'hBBBB);
      step();
      idle();
      set_rd(0, 7);
      set_rd(1, 7);
      @(negedge clk);
      check("x7 array prio byp", bus_a.rd_data[63:0], 64'hBBBB);
      check("x7 array prio nobyp", bus_b.rd_data[127:64], 64'hBBBB);
      step();

      // Issue x9, then writeback.
      idle();
      iss_en   = 1'b1;
      iss_addr = 5'd9;
      step();
      idle();
      set_rd(0, 9);
      @(negedge clk);
      check("x9 pending set", 64'(bus_a.pending[9]), 64'h1);
      check("x9 valid byp", 64'(bus_a.rd_valid[0]), 64'h0);
      check("x9 valid nobyp", 64'(bus_b.rd_valid[0]), 64'h0);
      step();
      idle();
      set_rd(0, 9);
      set_wr(0, 9, 64'h55);
      @(negedge clk);
      check("x9 wb bypass", bus_a.rd_data[63:0], 64'h55);
      check("x9 wb valid byp", 64'(bus_a.rd_valid[0]), 64'h1);
      check("x9 wb valid nobyp", 64'(bus_b.rd_valid[0]), 64'h0);
      step();
      idle();
      set_rd(0, 9);
      @(negedge clk);
      check("x9 pending clr", 64'(bus_a.pending[9]), 64'h0);
      check("x9 nobyp data", bus_b.rd_data[63:0], 64'h55);
      check("x9 nobyp valid", 64'(bus_b.rd_valid[0]), 64'h1);
      step();

      // Issue and writeback of x4 together: set wins, data still stored.
      idle();
      iss_en   = 1'b1;
      iss_addr = 5'd4;
      set_wr(0, 4, 64'h77);
      step();
      idle();
      set_rd(0, 4);
      @(negedge clk);
      check("x4 pending", 64'(bus_a.pending[4]), 64'h1);
      check("x4 array", bus_a.rd_data[63:0], 64'h77);
      check("x4 valid", 64'(bus_a.rd_valid[0]), 64'h0);
      step();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
      set_rd(0, 4);
      @(negedge clk);
      check("pending after mid rst", 64'(bus_a.pending), 64'h0);
      check("x4 after mid rst", bus_a.rd_data[63:0], 64'h0);
      step();

      // Random traffic with a narrow address range to force conflicts.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < NRD; p++) begin
            rd_en[p]            = $urandom_range(0, 3) != 0;
            rd_addr[p*AW +: AW] = AW'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
         end
         for (int p = 0; p < NWR; p++) begin
            wr_en[p]                = $urandom_range(0, 2) == 0;
            wr_addr[p*AW +: AW]     = AW'($urandom_range(0, 3) != 0 ? $urandom_range(0, 7) : $urandom_range(0, 31));
            wr_data[p*XLEN +: XLEN] = {$urandom, $urandom};
         end
         iss_en   = $urandom_range(0, 2) == 0;
         iss_addr = AW'($urandom_range(0, 7));
         step();
      end

      idle();
      rst = 1'b0;
      step();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
